csa_accum_ctrl: RTL and testbench

- Multi-operand accumulation sequencer built around the team's 3:2 carry-save compressor and a carry-resolve loop.
- Accepts a stream of W-bit unsigned operands over a valid/ready handshake and keeps the running total in redundant sum/carry registers, one operand per cycle.
- On the last operand it resolves the carries iteratively, then presents the binary total on an output valid/ready handshake.
- Sits between an operand producer (e.g. a partial-product or sample source) and any consumer of the total.

---
 rtl/csa_accum_ctrl_if.sv | 29 ++
 rtl/csa_accum_ctrl.sv | 109 ++++++++++
 tb/tb_csa_accum_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_ctrl_if.sv
// Operand/result handshake bundle for csa_accum_ctrl.
// master = producer/consumer side, slave = controller side.
interface csa_accum_ctrl_if #(
   parameter int W       = 8,
   parameter int MAX_OPS = 16
);
   localparam int OW = W + $clog2(MAX_OPS);
   localparam int CW = $clog2(MAX_OPS) + 1;

   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_last;
   logic          in_ready;
   logic          out_valid;
   logic [OW-1:0] out_sum;
   logic [CW-1:0] out_count;
   logic          out_trunc;
   logic          out_ready;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_trunc
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_trunc
   );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: 3:2 carry-save compress per operand,
// iterative carry resolve, then result handshake.
module csa_accum_ctrl #(
   parameter int W       = 8,
   parameter int MAX_OPS = 16
) (
   input  logic              clk,
   input  logic              rst,
   csa_accum_ctrl_if.slave   bus,
   output logic              busy
);
   localparam int OW = W + $clog2(MAX_OPS);
   localparam int CW = $clog2(MAX_OPS) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESOLVE,
      DONE
   } state_t;

   state_t        state, state_nxt;
   logic [OW-1:0] s_reg, s_nxt;
   logic [OW-1:0] c_reg, c_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          trunc, trunc_nxt;

   logic [OW-1:0] op;
   logic [CW-1:0] count_inc;
   logic          accept;

   assign op        = {{(OW-W){1'b0}}, bus.in_data};
   assign count_inc = count + 1'b1;

   // State and redundant accumulator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         s_reg <= '0;
         c_reg <= '0;
         count <= '0;
         trunc <= 1'b0;
      end else begin
         state <= state_nxt;
         s_reg <= s_nxt;
         c_reg <= c_nxt;
         count <= count_nxt;
         trunc <= trunc_nxt;
      end
   end

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_nxt     = state;
      s_nxt         = s_reg;
      c_nxt         = c_reg;
      count_nxt     = count;
      trunc_nxt     = trunc;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_sum   = '0;
      bus.out_count = '0;
      bus.out_trunc = 1'b0;
      busy          = (state != IDLE);
      accept        = 1'b0;

      unique case (state)
         IDLE, ACCUM: begin
            bus.in_ready = 1'b1;
            accept       = bus.in_valid;
            if (accept) begin
               s_nxt     = s_reg ^ c_reg ^ op;
               c_nxt     = ((s_reg & c_reg) | (s_reg & op) | (c_reg & op)) << 1;
               count_nxt = count_inc;
               if (bus.in_last) begin
                  state_nxt = RESOLVE;
               end else if (count_inc == CW'(MAX_OPS)) begin
                  state_nxt = RESOLVE;
                  trunc_nxt = 1'b1;
               end else begin
                  state_nxt = ACCUM;
               end
            end
         end
         RESOLVE: begin
            if (c_reg == '0) begin
               state_nxt = DONE;
            end else begin
               s_nxt = s_reg ^ c_reg;
               c_nxt = (s_reg & c_reg) << 1;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.out_sum   = s_reg;
            bus.out_count = count;
            bus.out_trunc = trunc;
            if (bus.out_ready) begin
               state_nxt = IDLE;
               s_nxt     = '0;
               c_nxt     = '0;
               count_nxt = '0;
               trunc_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl.
// Expected totals are pushed as operands are sent, popped on result.
module tb_csa_accum_ctrl;
   localparam int W       = 8;
   localparam int MAX_OPS = 16;
   localparam int OW      = W + $clog2(MAX_OPS);
   localparam int CW      = $clog2(MAX_OPS) + 1;

   logic clk;
   logic rst;
   logic busy;

   csa_accum_ctrl_if #(.W(W), .MAX_OPS(MAX_OPS)) bus ();

   csa_accum_ctrl #(.W(W), .MAX_OPS(MAX_OPS)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   int errors = 0;
   int checks = 0;

   logic [OW-1:0] q_sum[$];
   logic [CW-1:0] q_cnt[$];
   logic          q_trunc[$];

   int            acc_sum;
   int            acc_cnt;

   logic [OW-1:0] e_sum;
   logic [CW-1:0] e_cnt;
   logic          e_trunc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic send(input logic [W-1:0] d, input logic last);
      logic rdy;
      int   n;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      n = 0;
      forever begin
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
         if (rdy) break;
         if (n > 100) begin
            $display("FAIL send_timeout in_ready stuck=0 required=1");
            errors++;
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      acc_sum += int'(d);
      acc_cnt++;
   endtask

   task automatic push_group(input logic trunc);
      q_sum.push_back(OW'(acc_sum));
      q_cnt.push_back(CW'(acc_cnt));
      q_trunc.push_back(trunc);
      acc_sum = 0;
      acc_cnt = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_out(output int n, output bit ok);
      n  = 0;
      ok = 1'b1;
      while (bus.out_valid !== 1'b1) begin
         if (n >= 200) begin
            ok = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic pop_exp;
      e_sum   = q_sum.pop_front();
      e_cnt   = q_cnt.pop_front();
      e_trunc = q_trunc.pop_front();
   endtask

   task automatic handshake;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(2);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.out_sum !== '0 || bus.out_count !== '0 ||
          bus.out_trunc !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset rdy=%b ov=%b sum=%h cnt=%0d tr=%b busy=%b required 1 0 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count,
                  bus.out_trunc, busy);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_reset_mid_resolve;
      int n;
      bit ok;
      send(8'hFF, 1'b0);
      send(8'h01, 1'b1);
      acc_sum = 0;
      acc_cnt = 0;
      idle(3);
      checks++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL resolve_busy busy=%b rdy=%b required 1 0", busy, bus.in_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.out_sum !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset rdy=%b ov=%b sum=%h busy=%b required 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.out_sum, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(8'h12, 1'b0);
      send(8'h34, 1'b1);
      push_group(1'b0);
      wait_out(n, ok);
      pop_exp();
      checks++;
      if (!ok || bus.out_sum !== e_sum || bus.out_count !== e_cnt) begin
         errors++;
         $display("FAIL post_reset_group ok=%0d sum=%h cnt=%0d required sum=%h cnt=%0d",
                  ok, bus.out_sum, bus.out_count, e_sum, e_cnt);
      end
      handshake();
   endtask

   task automatic test_carry_chain;
      int n;
      bit ok;
      send(8'hFF, 1'b0);
      send(8'h01, 1'b1);
      push_group(1'b0);
      wait_out(n, ok);
      pop_exp();
      checks++;
      if (!ok || n != 9) begin
         errors++;
         $display("FAIL carry_latency got=%0d edges required=9", n);
      end
      checks++;
      if (bus.out_sum !== e_sum || bus.out_count !== e_cnt ||
          bus.out_trunc !== e_trunc || e_sum !== 12'h100) begin
         errors++;
         $display("FAIL carry_result sum=%h cnt=%0d tr=%b required sum=%h cnt=%0d tr=%b",
                  bus.out_sum, bus.out_count, bus.out_trunc, e_sum, e_cnt, e_trunc);
      end
      handshake();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          busy !== 1'b0 || bus.out_sum !== '0) begin
         errors++;
         $display("FAIL after_handshake ov=%b rdy=%b busy=%b sum=%h required 0 1 0 0",
                  bus.out_valid, bus.in_ready, busy, bus.out_sum);
      end
   endtask

   task automatic test_single;
      int n;
      bit ok;
      send(8'h5A, 1'b1);
      push_group(1'b0);
      wait_out(n, ok);
      pop_exp();
      checks++;
      if (!ok || n != 1) begin
         errors++;
         $display("FAIL single_latency got=%0d edges required=1", n);
      end
      checks++;
      if (bus.out_sum !== e_sum || bus.out_count !== e_cnt ||
          bus.out_trunc !== e_trunc) begin
         errors++;
         $display("FAIL single_result sum=%h cnt=%0d tr=%b required sum=%h cnt=%0d tr=%b",
                  bus.out_sum, bus.out_count, bus.out_trunc, e_sum, e_cnt, e_trunc);
      end
      handshake();
   endtask

   task automatic test_trunc;
      int n;
      bit ok;
      for (int i = 0; i < MAX_OPS; i++) send(8'hFF, 1'b0);
      push_group(1'b1);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL trunc_ready rdy=%b required=0", bus.in_ready);
      end
      wait_out(n, ok);
      pop_exp();
      checks++;
      if (!ok || bus.out_sum !== e_sum || bus.out_count !== e_cnt ||
          bus.out_trunc !== e_trunc) begin
         errors++;
         $display("FAIL trunc_result sum=%h cnt=%0d tr=%b required sum=%h cnt=%0d tr=%b",
                  bus.out_sum, bus.out_count, bus.out_trunc, e_sum, e_cnt, e_trunc);
      end
      handshake();
   endtask

   task automatic test_backpressure;
      int n;
      bit ok;
      int bad;
      send(8'h10, 1'b0);
      send(8'h20, 1'b1);
      push_group(1'b0);
      wait_out(n, ok);
      pop_exp();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h33;
      bus.in_last  = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid !== 1'b1 || bus.out_sum !== e_sum ||
             bus.out_count !== e_cnt || bus.in_ready !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (!ok || bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold bad_cycles=%0d sum=%h required sum=%h rdy=0",
                  bad, bus.out_sum, e_sum);
      end
      handshake();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_handoff ov=%b rdy=%b required 0 1",
                  bus.out_valid, bus.in_ready);
      end
      send(8'h33, 1'b1);
      push_group(1'b0);
      wait_out(n, ok);
      pop_exp();
      checks++;
      if (!ok || bus.out_sum !== e_sum || bus.out_count !== e_cnt) begin
         errors++;
         $display("FAIL bp_next_group sum=%h cnt=%0d required sum=%h cnt=%0d",
                  bus.out_sum, bus.out_count, e_sum, e_cnt);
      end
      handshake();
   endtask

   task automatic test_random_gaps;
      int n;
      bit ok;
      logic [W-1:0] ops [5];
      ops[0] = 8'd3;
      ops[1] = 8'd7;
      ops[2] = 8'd11;
      ops[3] = 8'd250;
      ops[4] = 8'd1;
      for (int i = 0; i < 5; i++) begin
         bus.in_last = 1'b1;
         idle($urandom_range(0, 3));
         bus.in_last = 1'b0;
         send(ops[i], (i == 4));
      end
      push_group(1'b0);
      wait_out(n, ok);
      pop_exp();
      checks++;
      if (!ok || bus.out_sum !== e_sum || bus.out_count !== e_cnt ||
          bus.out_trunc !== e_trunc || e_sum !== 12'h110) begin
         errors++;
         $display("FAIL gaps_result sum=%h cnt=%0d tr=%b required sum=%h cnt=%0d tr=%b",
                  bus.out_sum, bus.out_count, bus.out_trunc, e_sum, e_cnt, e_trunc);
      end
      handshake();
   endtask

   task automatic test_back_to_back;
      int n;
      bit ok;
      for (int g = 0; g < 4; g++) begin
         for (int i = 0; i <= g; i++)
            send(W'($urandom_range(0, 255)), (i == g));
         push_group(1'b0);
         wait_out(n, ok);
         pop_exp();
         checks++;
         if (!ok || bus.out_sum !== e_sum || bus.out_count !== e_cnt ||
             bus.out_trunc !== 1'b0) begin
            errors++;
            $display("FAIL b2b_group%0d sum=%h cnt=%0d required sum=%h cnt=%0d",
                     g, bus.out_sum, bus.out_count, e_sum, e_cnt);
         end
         handshake();
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b0;
      acc_sum      = 0;
      acc_cnt      = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_reset_mid_resolve();
      test_carry_chain();
      test_single();
      test_trunc();
      test_backpressure();
      test_random_gaps();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
